instruction_fetch: RTL and testbench

Instruction-fetch stage of the DLX pipeline. It holds the program counter and the instruction memory, and selects the next PC from sequential, jump and branch sources. It presents each fetched instruction plus PC+1 to the IF/ID latch, together with a capture enable. It also owns the run-control state machine (program load, continuous run, single-step, halt) driven by the debug unit.

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_memory.sv | 34 +++
 rtl/instruction_fetch.sv | 119 +++++++++++
 tb/tb_instruction_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the DLX instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the word-address width, the HALT/NOP instruction words and the
// run-control state encoding that o_state exposes to the debug unit.
package instruction_fetch_pkg;

  localparam int          ADDRWIDTH = 8;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/instruction_memory.sv
// Program RAM: synchronous write, combinational read, no reset on contents.
// Latency: read 0 cycles (same-cycle data), write lands on the next rising edge.
// Backpressure: none; always accepts a write and always returns read data.
//
// Ports:
//   i_clock            write clock
//   i_wr_en/addr/data  write port
//   i_rd_addr          read address (current PC)
//   o_rd_data          word at i_rd_addr
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clock,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  logic [NB_DATA-1:0] r_mem [2**NB_ADDR];

  // Contents are deliberately not reset so a loaded program survives a
  // debug-unit reset.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// DLX fetch stage: PC register, next-PC select and debug run-control FSM.
// Latency: fetch outputs combinational from PC/state; redirect takes effect next cycle.
// Backpressure: i_enable=0 (stall) or missing i_step in STEP holds the PC.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_enable, i_jump/i_jump_addr, i_branch/i_branch_addr   pipeline control
//   i_load, i_wr_en/addr/data, i_start, i_mode, i_step      debug unit
//   o_pc (PC+1), o_instruction, o_fetch_en                  to IF/ID latch
//   o_halt, o_state                                         status to debug unit
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                 NB_DATA     = 32,
  parameter int                 NB_ADDR     = ADDRWIDTH,
  parameter logic [NB_DATA-1:0] HALT_OPCODE = HALT_WORD
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_jump,
  input  logic [NB_ADDR-1:0] i_jump_addr,
  input  logic               i_branch,
  input  logic [NB_ADDR-1:0] i_branch_addr,
  input  logic               i_load,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic               i_step,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_DATA-1:0] o_instruction,
  output logic               o_fetch_en,
  output logic               o_halt,
  output logic [1:0]         o_state
);

  state_e             r_state;
  state_e             w_state_next;
  logic [NB_ADDR-1:0] r_pc;
  logic [NB_ADDR-1:0] w_pc_next;
  logic [NB_ADDR-1:0] w_pc_inc;
  logic [NB_DATA-1:0] w_word;
  logic               w_fetch_en;
  logic               w_mem_we;

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .i_clock   (i_clock),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_pc),
    .o_rd_data (w_word)
  );

  // Wraps modulo 2^NB_ADDR by construction.
  assign w_pc_inc = r_pc + NB_ADDR'(1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_LOAD;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fetch_en   = 1'b0;
    w_mem_we     = 1'b0;

    case (r_state)
      ST_LOAD: begin
        // A write in the start cycle still lands; the state change does not block it.
        w_mem_we = i_wr_en;
        if (i_start) begin
          w_state_next = i_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN:  w_fetch_en = i_enable;
      ST_STEP: w_fetch_en = i_enable & i_step;
      default: w_fetch_en = 1'b0;
    endcase

    if (w_fetch_en) begin
      // Branch comes from the older instruction (EX), so it wins over jump (ID).
      // A HALT word alongside any redirect is on the wrong path and is dropped.
      if (i_branch) begin
        w_pc_next = i_branch_addr;
      end else if (i_jump) begin
        w_pc_next = i_jump_addr;
      end else if (w_word == HALT_OPCODE) begin
        // PC parks on the HALT word; fetch_en is 0 in HALT so it is captured once.
        w_state_next = ST_HALT;
      end else begin
        w_pc_next = w_pc_inc;
      end
    end

    if (i_load) begin
      w_state_next = ST_LOAD;
      w_pc_next    = '0;
    end
  end

  assign o_fetch_en    = w_fetch_en;
  assign o_instruction = (r_state == ST_LOAD) ? NB_DATA'(NOP_WORD) : w_word;
  assign o_pc          = w_pc_inc;
  assign o_halt        = (r_state == ST_HALT);
  assign o_state       = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a fetch scoreboard.
// Latency: expects fetch outputs in the same cycle the stimulus enables them.
// Backpressure: exercises stalls and single-step gating.
module tb_instruction_fetch;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic               clk;
  logic               rst_n;
  logic               i_enable;
  logic               i_jump;
  logic [NB_ADDR-1:0] i_jump_addr;
  logic               i_branch;
  logic [NB_ADDR-1:0] i_branch_addr;
  logic               i_load;
  logic               i_wr_en;
  logic [NB_ADDR-1:0] i_wr_addr;
  logic [NB_DATA-1:0] i_wr_data;
  logic               i_start;
  logic               i_mode;
  logic               i_step;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_DATA-1:0] o_instruction;
  logic               o_fetch_en;
  logic               o_halt;
  logic [1:0]         o_state;

  instruction_fetch #(
    .NB_DATA     (NB_DATA),
    .NB_ADDR     (NB_ADDR),
    .HALT_OPCODE (HALT)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_enable      (i_enable),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .i_branch      (i_branch),
    .i_branch_addr (i_branch_addr),
    .i_load        (i_load),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_step        (i_step),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_fetch_en    (o_fetch_en),
    .o_halt        (o_halt),
    .o_state       (o_state)
  );

  typedef struct {
    logic [31:0]        instr;
    logic [NB_ADDR-1:0] pc;
  } fetch_t;

  fetch_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [NB_ADDR-1:0] pc);
    fetch_t f;
    f.instr = instr;
    f.pc    = pc;
    exp_q.push_back(f);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    i_load   = 1'b0;
    i_wr_en  = 1'b0;
    i_start  = 1'b0;
    i_step   = 1'b0;
    i_branch = 1'b0;
    i_jump   = 1'b0;
  endtask

  // Monitor: every presented fetch must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && o_fetch_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got instr %h pc %h expected no fetch", o_instruction, o_pc);
      end else begin
        fetch_t f;
        f = exp_q.pop_front();
        chk("fetch_instr", o_instruction, f.instr);
        chk("fetch_pc", 32'(o_pc), 32'(f.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Program image: address/data pairs written during LOAD.
  logic [NB_ADDR-1:0] prog_a [11];
  logic [31:0]        prog_d [11];

  initial begin
    prog_a = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'h21, 8'h40, 8'h41, 8'hFF};
    prog_d = '{32'h11, 32'h22, 32'h33, HALT, 32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hC0, 32'hC1, 32'hEE};

    rst_n = 1'b0;
    i_enable = 1'b1;
    i_mode = 1'b0;
    i_jump_addr = '0;
    i_branch_addr = '0;
    i_wr_addr = '0;
    i_wr_data = '0;
    clr();
    repeat (2) @(posedge clk);
    mid();
    chk("rst_fetch_en", 32'(o_fetch_en), 32'd0);
    chk("rst_halt", 32'(o_halt), 32'd0);
    chk("rst_instr", o_instruction, 32'd0);
    chk("rst_pc", 32'(o_pc), 32'd1);
    chk("rst_state", 32'(o_state), 32'd0);
    #1 rst_n = 1'b1;
    next();

    // Load program
    i_load = 1'b1;
    next();
    clr();
    for (int i = 0; i < 11; i++) begin
      i_wr_en = 1'b1;
      i_wr_addr = prog_a[i];
      i_wr_data = prog_d[i];
      next();
    end
    clr();

    // Continuous run with a 2-cycle stall at PC=1
    i_start = 1'b1;
    i_mode = 1'b0;
    next();
    clr();
    push(32'h11, 8'd1);
    next();
    i_enable = 1'b0;
    mid();
    chk("stall_fetch_en", 32'(o_fetch_en), 32'd0);
    chk("stall_instr", o_instruction, 32'h22);
    next();
    mid();
    chk("stall_instr2", o_instruction, 32'h22);
    chk("stall_pc2", 32'(o_pc), 32'd2);
    next();
    i_enable = 1'b1;
    push(32'h22, 8'd2);
    next();
    push(32'h33, 8'd3);
    next();
    push(HALT, 8'd4);
    next();
    mid();
    chk("halt_flag", 32'(o_halt), 32'd1);
    chk("halt_state", 32'(o_state), 32'd3);
    chk("halt_pc_held", 32'(o_pc), 32'd4);
    chk("halt_fetch_en", 32'(o_fetch_en), 32'd0);
    next();
    mid();
    chk("halt_stays", 32'(o_halt), 32'd1);
    next();

    // Reload from HALT
    i_load = 1'b1;
    next();
    clr();
    mid();
    chk("reload_state", 32'(o_state), 32'd0);
    chk("reload_instr", o_instruction, 32'd0);
    chk("reload_pc", 32'(o_pc), 32'd1);
    chk("reload_halt", 32'(o_halt), 32'd0);
    next();

    // Redirect priority, wrap and wrong-path HALT
    i_start = 1'b1;
    next();
    clr();
    i_branch = 1'b1; i_branch_addr = 8'h20;
    i_jump = 1'b1;   i_jump_addr = 8'h40;
    push(32'h11, 8'd1);
    next();
    clr();
    i_jump = 1'b1; i_jump_addr = 8'h40;
    push(32'hB0, 8'h21);
    next();
    clr();
    push(32'hC0, 8'h41);
    next();
    i_jump = 1'b1; i_jump_addr = 8'hFF;
    push(32'hC1, 8'h42);
    next();
    clr();
    push(32'hEE, 8'h00);
    next();
    push(32'h11, 8'd1);
    next();
    push(32'h22, 8'd2);
    next();
    push(32'h33, 8'd3);
    next();
    i_jump = 1'b1; i_jump_addr = 8'h10;
    push(HALT, 8'd4);
    next();
    clr();
    push(32'hA0, 8'h11);
    mid();
    chk("wrongpath_state", 32'(o_state), 32'd1);
    chk("wrongpath_halt", 32'(o_halt), 32'd0);
    next();

    // Stall with a redirect present: PC must hold at 0x11
    i_enable = 1'b0;
    i_branch = 1'b1; i_branch_addr = 8'h20;
    mid();
    chk("stall_redir_pc", 32'(o_pc), 32'h12);
    next();
    mid();
    chk("stall_redir_pc2", 32'(o_pc), 32'h12);
    chk("stall_redir_instr", o_instruction, 32'hA1);

    // Async reset mid-RUN, checked before the next edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fetch_en", 32'(o_fetch_en), 32'd0);
    chk("arst_halt", 32'(o_halt), 32'd0);
    chk("arst_instr", o_instruction, 32'd0);
    chk("arst_pc", 32'(o_pc), 32'd1);
    chk("arst_state", 32'(o_state), 32'd0);
    clr();
    i_enable = 1'b1;
    #1 rst_n = 1'b1;
    next();

    // Single-step mode
    i_start = 1'b1;
    i_mode = 1'b1;
    next();
    clr();
    mid();
    chk("step_idle_fetch_en", 32'(o_fetch_en), 32'd0);
    chk("step_idle_instr", o_instruction, 32'h11);
    chk("step_state", 32'(o_state), 32'd2);
    next();
    i_wr_en = 1'b1; i_wr_addr = 8'h01; i_wr_data = 32'h0000_DEAD;
    next();
    clr();
    i_step = 1'b1;
    i_start = 1'b1;
    i_mode = 1'b0;
    push(32'h11, 8'd1);
    next();
    clr();
    mid();
    chk("step_state_kept", 32'(o_state), 32'd2);
    chk("step_mem_protected", o_instruction, 32'h22);
    next();
    i_step = 1'b1;
    i_enable = 1'b0;
    mid();
    chk("step_stalled", 32'(o_fetch_en), 32'd0);
    next();
    i_enable = 1'b1;
    push(32'h22, 8'd2);
    next();
    push(32'h33, 8'd3);
    next();
    clr();
    next();
    i_step = 1'b1;
    push(HALT, 8'd4);
    next();
    clr();
    mid();
    chk("step_halt", 32'(o_halt), 32'd1);
    chk("step_halt_state", 32'(o_state), 32'd3);
    next();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
